arm_pipe_controller: RTL and testbench

Pipelined control unit for the 5-stage ARM subset core. It decodes the fetched-and-latched instruction field `InstrC[31:12]` in Decode and carries the control word through Execute, Memory and Writeback in lock-step with the datapath. It holds the NZCV flags register, evaluates condition codes in Execute and resolves branches. It also exports the pipeline status the hazard unit needs.

---
 rtl/arm_pipe_controller.sv | 199 +++++++++++++++++++
 tb/tb_arm_pipe_controller.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/arm_pipe_controller.sv
// Pipelined control unit for the 5-stage ARM subset core: decode, D/E/M/W control registers, NZCV flags.
// Optional feature macro CTRL_COND_EXEC_EN enables condition-code evaluation; undefined ties CondEx to 1.
module arm_pipe_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:12] InstrC,
  input  logic [3:0]  ALUFlags,
  input  logic        FlushE,
  output logic [1:0]  RegSrcD,
  output logic [1:0]  ImmSrcD,
  output logic        ALUSrcE,
  output logic [1:0]  ALUControlE,
  output logic        BranchTakenE,
  output logic        MemWriteM,
  output logic        RegWriteW,
  output logic        MemtoRegW,
  output logic        PCSrcW,
  output logic        RegWriteM,
  output logic        MemtoRegE,
  output logic        PCWrPendingF
);

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;

  logic       reg_w_d, mem_w_d, mtr_d, alu_src_d, branch_d, pcs_d;
  logic [1:0] alu_ctrl_d, flag_w_d;

  logic       reg_w_e, mem_w_e, branch_e, pcs_e;
  logic [1:0] flag_w_e;
  logic       cond_ex;
  logic       reg_write_e, mem_write_e, pcs_q_e;

  logic       mtr_m, pcs_m;
  logic [3:0] flags;
  logic       unused_ok;

  assign op    = InstrC[27:26];
  assign funct = InstrC[25:20];
  assign rd    = InstrC[15:12];

  // Decode: main decoder plus ALU/flag-write decode for data processing
  always_comb begin
    reg_w_d    = 1'b0;
    mem_w_d    = 1'b0;
    mtr_d      = 1'b0;
    alu_src_d  = 1'b0;
    branch_d   = 1'b0;
    alu_ctrl_d = 2'b00;
    flag_w_d   = 2'b00;
    RegSrcD    = 2'b00;
    ImmSrcD    = 2'b00;
    case (op)
      OP_DP: begin
        reg_w_d   = 1'b1;
        alu_src_d = funct[5];
        case (funct[4:1])
          CMD_ADD: alu_ctrl_d = 2'b00;
          CMD_SUB: alu_ctrl_d = 2'b01;
          CMD_AND: alu_ctrl_d = 2'b10;
          CMD_ORR: alu_ctrl_d = 2'b11;
          default: begin
            alu_ctrl_d = 2'b00;
            reg_w_d    = 1'b0;
          end
        endcase
        flag_w_d[1] = funct[0];
        flag_w_d[0] = funct[0] & ((funct[4:1] == CMD_ADD) | (funct[4:1] == CMD_SUB));
      end
      OP_MEM: begin
        alu_src_d = 1'b1;
        ImmSrcD   = 2'b01;
        if (funct[0]) begin
          reg_w_d = 1'b1;
          mtr_d   = 1'b1;
        end else begin
          mem_w_d = 1'b1;
          RegSrcD = 2'b10;
        end
      end
      OP_BR: begin
        branch_d  = 1'b1;
        alu_src_d = 1'b1;
        ImmSrcD   = 2'b10;
        RegSrcD   = 2'b01;
      end
      default: ;
    endcase
    pcs_d = (rd == 4'hF) & reg_w_d;
  end

  // D->E control register; a flush loads a full bubble
  always_ff @(posedge clk) begin
    if (reset || FlushE) begin
      reg_w_e     <= 1'b0;
      mem_w_e     <= 1'b0;
      branch_e    <= 1'b0;
      pcs_e       <= 1'b0;
      flag_w_e    <= 2'b00;
      MemtoRegE   <= 1'b0;
      ALUSrcE     <= 1'b0;
      ALUControlE <= 2'b00;
    end else begin
      reg_w_e     <= reg_w_d;
      mem_w_e     <= mem_w_d;
      branch_e    <= branch_d;
      pcs_e       <= pcs_d;
      flag_w_e    <= flag_w_d;
      MemtoRegE   <= mtr_d;
      ALUSrcE     <= alu_src_d;
      ALUControlE <= alu_ctrl_d;
    end
  end

`ifdef CTRL_COND_EXEC_EN
  logic [3:0] cond_e;

  always_ff @(posedge clk) begin
    if (reset) cond_e <= 4'h0;
    else       cond_e <= InstrC[31:28];
  end

  // Condition check against the committed flags (N Z C V = flags[3:0])
  always_comb begin
    cond_ex = 1'b0;
    case (cond_e)
      4'b0000: cond_ex = flags[2];
      4'b0001: cond_ex = ~flags[2];
      4'b0010: cond_ex = flags[1];
      4'b0011: cond_ex = ~flags[1];
      4'b0100: cond_ex = flags[3];
      4'b0101: cond_ex = ~flags[3];
      4'b0110: cond_ex = flags[0];
      4'b0111: cond_ex = ~flags[0];
      4'b1000: cond_ex = flags[1] & ~flags[2];
      4'b1001: cond_ex = ~flags[1] | flags[2];
      4'b1010: cond_ex = (flags[3] == flags[0]);
      4'b1011: cond_ex = (flags[3] != flags[0]);
      4'b1100: cond_ex = ~flags[2] & (flags[3] == flags[0]);
      4'b1101: cond_ex = flags[2] | (flags[3] != flags[0]);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  assign unused_ok = ^InstrC[19:16];
`else
  assign cond_ex   = 1'b1;
  assign unused_ok = ^{InstrC[31:28], InstrC[19:16], flags};
`endif

  assign reg_write_e  = reg_w_e & cond_ex;
  assign mem_write_e  = mem_w_e & cond_ex;
  assign pcs_q_e      = pcs_e & cond_ex;
  assign BranchTakenE = branch_e & cond_ex;
  assign PCWrPendingF = pcs_d | pcs_q_e | pcs_m;

  // NZ and CV update independently; no bypass into the same cycle's condition check
  always_ff @(posedge clk) begin
    if (reset) begin
      flags <= 4'h0;
    end else begin
      if (flag_w_e[1] & cond_ex) flags[3:2] <= ALUFlags[3:2];
      if (flag_w_e[0] & cond_ex) flags[1:0] <= ALUFlags[1:0];
    end
  end

  // E->M and M->W registers carry only qualified side effects
  always_ff @(posedge clk) begin
    if (reset) begin
      RegWriteM <= 1'b0;
      MemWriteM <= 1'b0;
      mtr_m     <= 1'b0;
      pcs_m     <= 1'b0;
      RegWriteW <= 1'b0;
      MemtoRegW <= 1'b0;
      PCSrcW    <= 1'b0;
    end else begin
      RegWriteM <= reg_write_e;
      MemWriteM <= mem_write_e;
      mtr_m     <= MemtoRegE;
      pcs_m     <= pcs_q_e;
      RegWriteW <= RegWriteM;
      MemtoRegW <= mtr_m;
      PCSrcW    <= pcs_m;
    end
  end

endmodule

// File: tb/tb_arm_pipe_controller.sv
// Self-checking bench for arm_pipe_controller: decode vector table, scoreboard for later stages,
// hand sequences for flags, conditional execution, flush and mid-pipeline reset.
module tb_arm_pipe_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:12] InstrC;
  logic [3:0]  ALUFlags;
  logic        FlushE;
  logic [1:0]  RegSrcD, ImmSrcD, ALUControlE;
  logic        ALUSrcE, BranchTakenE, MemWriteM, RegWriteW, MemtoRegW, PCSrcW;
  logic        RegWriteM, MemtoRegE, PCWrPendingF;

  arm_pipe_controller dut (
    .clk(clk), .reset(reset), .InstrC(InstrC), .ALUFlags(ALUFlags), .FlushE(FlushE),
    .RegSrcD(RegSrcD), .ImmSrcD(ImmSrcD), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
    .BranchTakenE(BranchTakenE), .MemWriteM(MemWriteM), .RegWriteW(RegWriteW),
    .MemtoRegW(MemtoRegW), .PCSrcW(PCSrcW), .RegWriteM(RegWriteM), .MemtoRegE(MemtoRegE),
    .PCWrPendingF(PCWrPendingF)
  );

  always #5 clk = ~clk;

`ifdef CTRL_COND_EXEC_EN
  localparam bit COND_EN = 1'b1;
`else
  localparam bit COND_EN = 1'b0;
`endif

  localparam logic [19:0] NOP    = 20'hEC000;
  localparam logic [19:0] ADDS   = 20'hE2921;
  localparam logic [19:0] SUBS   = 20'hE0521;
  localparam logic [19:0] BEQ    = 20'h0A000;
  localparam logic [19:0] ADDEQ  = 20'h02821;
  localparam logic [19:0] LDR_PC = 20'hE591F;

  localparam int K_ALUSRC_E = 0, K_ALUCTL_E = 1, K_BR_E = 2, K_MTR_E = 3, K_MEMW_M = 4;
  localparam int K_REGW_M = 5, K_REGW_W = 6, K_MTR_W = 7, K_PCS_W = 8, K_PEND = 9, K_FLAGS = 10;

  typedef struct {
    int         due;
    int         kind;
    logic [3:0] exp;
    string      name;
  } sb_t;

  typedef struct {
    logic [19:0] instr;
    logic [1:0]  reg_src;
    logic [1:0]  imm_src;
    logic        alu_src;
    logic [1:0]  alu_ctrl;
    logic        br;
    logic        mem_w;
    logic        reg_w;
    logic        mtr;
    logic        pcs;
    string       name;
  } vec_t;

  sb_t  sb_q[$];
  vec_t vecs[11];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [3:0] sig_val(input int k);
    case (k)
      K_ALUSRC_E: return {3'b000, ALUSrcE};
      K_ALUCTL_E: return {2'b00, ALUControlE};
      K_BR_E:     return {3'b000, BranchTakenE};
      K_MTR_E:    return {3'b000, MemtoRegE};
      K_MEMW_M:   return {3'b000, MemWriteM};
      K_REGW_M:   return {3'b000, RegWriteM};
      K_REGW_W:   return {3'b000, RegWriteW};
      K_MTR_W:    return {3'b000, MemtoRegW};
      K_PCS_W:    return {3'b000, PCSrcW};
      K_PEND:     return {3'b000, PCWrPendingF};
      K_FLAGS:    return dut.flags;
      default:    return 4'bxxxx;
    endcase
  endfunction

  // ARM condition semantics: base test on cond[3:1], cond[0] inverts, 1111 never
  function automatic logic cond_model(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v, base;
    {n, z, cf, v} = f;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cf;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cf && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    if (c == 4'hF) return 1'b0;
    return c[0] ? !base : base;
  endfunction

  task automatic expect_at(input int dly, input int k, input logic [3:0] v, input string nm);
    sb_q.push_back('{cyc + dly, k, v, nm});
  endtask

  task automatic check_due();
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].due == cyc) begin
        chk(sb_q[i].name, sig_val(sb_q[i].kind), sb_q[i].exp);
        sb_q.delete(i);
      end
    end
  endtask

  task automatic cycle_begin(input logic [19:0] ins, input logic fl, input logic [3:0] af);
    InstrC   = ins;
    FlushE   = fl;
    ALUFlags = af;
    #4;
    check_due();
  endtask

  task automatic cycle_end();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      cycle_begin(NOP, 1'b0, 4'h0);
      cycle_end();
    end
  endtask

  initial begin
    logic [3:0] fpat [4];
    vecs[0]  = '{20'hE2921, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "adds_imm"};
    vecs[1]  = '{20'hE0421, 2'b00, 2'b00, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "sub_reg"};
    vecs[2]  = '{20'hE0021, 2'b00, 2'b00, 1'b0, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "and_reg"};
    vecs[3]  = '{20'hE3821, 2'b00, 2'b00, 1'b1, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "orr_imm"};
    vecs[4]  = '{20'hE0221, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "eor_unsup"};
    vecs[5]  = '{20'hE5921, 2'b00, 2'b01, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "ldr"};
    vecs[6]  = '{20'hE5821, 2'b10, 2'b01, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "str"};
    vecs[7]  = '{20'hEA000, 2'b01, 2'b10, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "b_al"};
    vecs[8]  = '{20'hEC000, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "nop"};
    vecs[9]  = '{20'hE591F, 2'b00, 2'b01, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, "ldr_pc"};
    vecs[10] = '{20'hE080F, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, "add_pc"};
    fpat[0] = 4'b0100; fpat[1] = 4'b1001; fpat[2] = 4'b0010; fpat[3] = 4'b1000;

    // Reset state
    reset = 1'b1; InstrC = NOP; FlushE = 1'b0; ALUFlags = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_regsrc", {2'b00, RegSrcD}, 4'h0);
    chk("rst_immsrc", {2'b00, ImmSrcD}, 4'h0);
    chk("rst_e", {ALUSrcE, ALUControlE, BranchTakenE}, 4'h0);
    chk("rst_m", {2'b00, MemWriteM, RegWriteM}, 4'h0);
    chk("rst_w", {1'b0, RegWriteW, MemtoRegW, PCSrcW}, 4'h0);
    chk("rst_misc", {2'b00, MemtoRegE, PCWrPendingF}, 4'h0);
    chk("rst_flags", dut.flags, 4'h0);
    reset = 1'b0;

    // Decode table, each instruction followed by bubbles
    for (int i = 0; i < 11; i++) begin
      expect_at(1, K_ALUSRC_E, 4'(vecs[i].alu_src), {vecs[i].name, "_alusrc"});
      expect_at(1, K_ALUCTL_E, 4'(vecs[i].alu_ctrl), {vecs[i].name, "_aluctl"});
      expect_at(1, K_BR_E, 4'(vecs[i].br), {vecs[i].name, "_brtaken"});
      expect_at(1, K_MTR_E, 4'(vecs[i].mtr), {vecs[i].name, "_mtr_e"});
      expect_at(2, K_MEMW_M, 4'(vecs[i].mem_w), {vecs[i].name, "_memw_m"});
      expect_at(2, K_REGW_M, 4'(vecs[i].reg_w), {vecs[i].name, "_regw_m"});
      expect_at(3, K_REGW_W, 4'(vecs[i].reg_w), {vecs[i].name, "_regw_w"});
      expect_at(3, K_MTR_W, 4'(vecs[i].mtr), {vecs[i].name, "_mtr_w"});
      expect_at(3, K_PCS_W, 4'(vecs[i].pcs), {vecs[i].name, "_pcs_w"});
      for (int d = 0; d < 3; d++) expect_at(d, K_PEND, 4'(vecs[i].pcs), {vecs[i].name, "_pend"});
      expect_at(3, K_PEND, 4'h0, {vecs[i].name, "_pend_w"});
      cycle_begin(vecs[i].instr, 1'b0, 4'h0);
      chk({vecs[i].name, "_regsrc"}, {2'b00, RegSrcD}, 4'(vecs[i].reg_src));
      chk({vecs[i].name, "_immsrc"}, {2'b00, ImmSrcD}, 4'(vecs[i].imm_src));
      cycle_end();
      idle(3);
    end

    // ADDS sets Z, BEQ is taken
    cycle_begin(ADDS, 1'b0, 4'h0);
    cycle_end();
    expect_at(1, K_FLAGS, 4'b0100, "adds_flags");
    expect_at(1, K_BR_E, 4'h1, "beq_z1_taken");
    cycle_begin(BEQ, 1'b0, 4'b0100);
    cycle_end();
    idle(3);

    // SUBS clears Z; BEQ and ADDEQ are squashed when conditions are evaluated
    cycle_begin(SUBS, 1'b0, 4'h0);
    cycle_end();
    expect_at(1, K_FLAGS, 4'b0000, "subs_flags");
    expect_at(1, K_BR_E, COND_EN ? 4'h0 : 4'h1, "beq_z0_taken");
    expect_at(2, K_REGW_M, 4'h0, "beq_z0_regw_m");
    expect_at(2, K_MEMW_M, 4'h0, "beq_z0_memw_m");
    cycle_begin(BEQ, 1'b0, 4'b0000);
    cycle_end();
    expect_at(3, K_REGW_W, COND_EN ? 4'h0 : 4'h1, "addeq_z0_regw_w");
    cycle_begin(ADDEQ, 1'b0, 4'h0);
    cycle_end();
    idle(3);

    // Condition-code sweep over several flag patterns
    for (int p = 0; p < 4; p++) begin
      cycle_begin(ADDS, 1'b0, 4'h0);
      cycle_end();
      for (int c = 0; c < 16; c++) begin
        expect_at(3, K_REGW_W, COND_EN ? 4'(cond_model(4'(c), fpat[p])) : 4'h1,
                  $sformatf("cond%0h_f%0h", c, fpat[p]));
        cycle_begin({4'(c), 16'h2821}, 1'b0, (c == 0) ? fpat[p] : 4'h0);
        cycle_end();
      end
      idle(3);
    end

    // LDR PC flushed before it reaches Execute
    expect_at(0, K_PEND, 4'h1, "ldrpc_fl_pend_d");
    expect_at(1, K_PEND, 4'h0, "ldrpc_fl_pend_e");
    expect_at(2, K_PEND, 4'h0, "ldrpc_fl_pend_m");
    expect_at(3, K_PCS_W, 4'h0, "ldrpc_fl_pcs_w");
    expect_at(3, K_REGW_W, 4'h0, "ldrpc_fl_regw_w");
    cycle_begin(LDR_PC, 1'b1, 4'h0);
    cycle_end();
    idle(4);

    // Flushed SUBS must not touch flags
    cycle_begin(ADDS, 1'b0, 4'h0);
    cycle_end();
    expect_at(1, K_FLAGS, 4'b0110, "pre_flush_flags");
    expect_at(2, K_FLAGS, 4'b0110, "subs_flushed_flags");
    expect_at(3, K_REGW_W, 4'h0, "subs_flushed_regw_w");
    cycle_begin(SUBS, 1'b1, 4'b0110);
    cycle_end();
    cycle_begin(NOP, 1'b0, 4'b1111);
    cycle_end();
    idle(3);

    // Reset with LDR PC in Memory discards it
    expect_at(2, K_REGW_M, 4'h1, "ldrpc_rst_regw_m");
    expect_at(3, K_REGW_W, 4'h0, "ldrpc_rst_regw_w");
    expect_at(3, K_MTR_W, 4'h0, "ldrpc_rst_mtr_w");
    expect_at(3, K_PCS_W, 4'h0, "ldrpc_rst_pcs_w");
    expect_at(3, K_PEND, 4'h0, "ldrpc_rst_pend");
    expect_at(3, K_FLAGS, 4'h0, "ldrpc_rst_flags");
    cycle_begin(LDR_PC, 1'b0, 4'h0);
    cycle_end();
    idle(1);
    cycle_begin(NOP, 1'b0, 4'h0);
    reset = 1'b1;
    cycle_end();
    reset = 1'b0;
    idle(4);

    foreach (sb_q[i]) begin
      checks++;
      errors++;
      $display("FAIL %s never checked (due cyc %0d)", sb_q[i].name, sb_q[i].due);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
